// File: rtl/seq_alu.sv
// Registered ALU with iterative shift-add multiply and restoring divide.
// Single-cycle ops update C/zero; mul/div deliver results through HI/LO.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               sgn_op, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial, diff;
    logic               geq;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        shamt   = B[SHW-1:0];
        alu_res = '0;
        case (ALUOp)
            4'd0:    alu_res = A + B;
            4'd1:    alu_res = A - B;
            4'd2:    alu_res = A & B;
            4'd3:    alu_res = A | B;
            4'd4:    alu_res = A >> shamt;
            4'd5:    alu_res = $signed(A) >>> shamt;
            4'd6:    alu_res = A ^ B;
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: alu_res = '0;
        endcase
    end

    // Odd mul/div op codes are the signed variants
    always_comb begin
        sgn_op = ALUOp[0];
        sign_a = sgn_op & A[WIDTH-1];
        sign_b = sgn_op & B[WIDTH-1];
        abs_a  = sign_a ? -A : A;
        abs_b  = sign_b ? -B : B;
    end

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
        trial    = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = trial - {1'b0, opb_q};
        geq      = ~diff[WIDTH];
        prod_fix = neg_q ? -acc_q : acc_q;
        q_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        r_fix    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        c_d      = c_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!ALUOp[3] || ALUOp[2]) begin
                        c_d    = alu_res;
                        zero_d = (alu_res == '0);
                        done_d = 1'b1;
                    end else if (ALUOp[1] && (B == '0)) begin
                        hi_d   = A;
                        lo_d   = '1;
                        done_d = 1'b1;
                    end else begin
                        is_div_d = ALUOp[1];
                        acc_d    = {{WIDTH{1'b0}}, (ALUOp[1] ? abs_a : abs_b)};
                        opb_d    = ALUOp[1] ? abs_b : abs_a;
                        neg_d    = sign_a ^ sign_b;
                        rneg_d   = sign_a;
                        cnt_d    = '0;
                        state_d  = ALUOp[1] ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            DIV: begin
                acc_d = {(geq ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], geq};
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            c_q      <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            c_q      <= c_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign C    = c_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign zero = zero_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
